// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 byte constants, controller FSM states and byte classification.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2
    } state_t;

    // Keyboard status/error bytes that never form a key event.
    function automatic logic is_drop(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_BAT) ||
               (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ECHO);
    endfunction

endpackage

// File: rtl/ps2_timeout_cnt.sv
// Down-counter that pulses expire_c after TIMEOUT_CYC consecutive run cycles without a clear.
module ps2_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire_c
);

    localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] rem;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rem <= LOAD;
        end else if (run) begin
            rem <= (rem == '0) ? LOAD : rem - TW'(1);
        end
    end

    // A clear in the same cycle means a byte was fetched, so the prefix is still live.
    assign expire_c = run && !clr && (rem == '0);

endmodule

// File: rtl/ps2_key_ctrl.sv
// Drains the PS/2 scan-code FIFO and turns set-2 byte sequences into key events.
module ps2_key_ctrl #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_release,
    output logic             key_repeat,
    output logic             key_down,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_err,
    input  logic             clr_err
);

    import ps2_pkg::*;

    state_t     state;
    logic [7:0] byte_r;
    logic       ext_pend;
    logic       brk_pend;
    logic       fetch;
    logic       pend;
    logic       tmo_expire_c;
    logic       held_match;

    assign fetch      = (state == IDLE) && en && ps2_ready;
    assign pend       = ext_pend || brk_pend;
    assign held_match = key_down && (held_code == byte_r) && (held_ext == ext_pend);

    // Pop strobe is a pure decode of the state register: low only during POP.
    assign ps2_nextdata_n = (state != POP);

    ps2_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr      (fetch || !pend),
        .run      (pend),
        .expire_c (tmo_expire_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_r      <= 8'h00;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
            key_down    <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            press_cnt   <= '0;
            ovf_err     <= 1'b0;
        end else begin
            key_valid <= 1'b0;

            if (ps2_overflow) begin
                ovf_err <= 1'b1;
            end else if (clr_err) begin
                ovf_err <= 1'b0;
            end

            if (tmo_expire_c) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fetch) begin
                        byte_r <= ps2_data;
                        state  <= POP;
                    end
                end
                POP: begin
                    state <= DECODE;
                end
                DECODE: begin
                    state <= IDLE;
                    if (byte_r == PS2_EXT) begin
                        ext_pend <= 1'b1;
                    end else if (byte_r == PS2_BRK) begin
                        brk_pend <= 1'b1;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        if (!is_drop(byte_r)) begin
                            key_valid   <= 1'b1;
                            key_code    <= byte_r;
                            key_ext     <= ext_pend;
                            key_release <= brk_pend;
                            if (brk_pend) begin
                                key_repeat <= 1'b0;
                                if (held_match) begin
                                    key_down <= 1'b0;
                                end
                            end else if (held_match) begin
                                key_repeat <= 1'b1;
                            end else begin
                                key_repeat <= 1'b0;
                                press_cnt  <= press_cnt + CNT_W'(1);
                                held_code  <= byte_r;
                                held_ext   <= ext_pend;
                                key_down   <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench: model FIFO, byte-level key-event reference model, directed and random stimulus.
module tb_ps2_key_ctrl;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TMO       = 16;
    localparam int          GAP_LIMIT = 25;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [7:0]       ps2_data;
    logic             ps2_ready;
    logic             ps2_overflow;
    logic             clr_err;
    logic             ps2_nextdata_n;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_release;
    logic             key_repeat;
    logic             key_down;
    logic [7:0]       held_code;
    logic             held_ext;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_err;

    ps2_key_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .en(en), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_release(key_release), .key_repeat(key_repeat), .key_down(key_down),
        .held_code(held_code), .held_ext(held_ext), .press_cnt(press_cnt),
        .ovf_err(ovf_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       rep;
        logic       down;
        logic [7:0] hcode;
        logic       hext;
        logic [7:0] cnt;
    } ev_t;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         pop_cnt = 0;
    int         valid_cnt = 0;
    logic [7:0] fifo[$];
    ev_t        exp_q[$];
    bit         prev_pop = 1'b0;

    // Reference model state, updated once per byte removed from the FIFO.
    bit         m_ext, m_brk, m_down, m_hext;
    logic [7:0] m_hcode;
    logic [7:0] m_cnt;
    int         last_pop;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        tests++;
        fails++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic update_fifo_out();
        ps2_ready = (fifo.size() != 0);
        ps2_data  = ps2_ready ? fifo[0] : 8'h00;
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_down = 0; m_hext = 0;
        m_hcode = 8'h00; m_cnt = 8'h00; last_pop = cyc;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input int c);
        ev_t e;
        bit  match;
        if ((m_ext || m_brk) && (c - last_pop > GAP_LIMIT)) begin
            m_ext = 0;
            m_brk = 0;
        end
        last_pop = c;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE}) begin
            m_ext = 0;
            m_brk = 0;
        end else begin
            e.due = c + 2;
            e.code = b;
            e.ext = m_ext;
            e.rel = m_brk;
            match = m_down && (m_hcode == b) && (m_hext == m_ext);
            if (m_brk) begin
                e.rep = 0;
                if (match) m_down = 0;
            end else if (match) begin
                e.rep = 1;
            end else begin
                e.rep = 0;
                m_cnt = m_cnt + 8'd1;
                m_hcode = b;
                m_hext = m_ext;
                m_down = 1;
            end
            e.down = m_down; e.hcode = m_hcode; e.hext = m_hext; e.cnt = m_cnt;
            exp_q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Per-cycle monitor: FIFO pops, handshake rules and event comparison.
    always @(negedge clk) begin
        ev_t        e;
        logic [7:0] b;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (key_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    fail_now("spurious_key_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_code", key_code, e.code);
                    check("ev_ext", 8'(key_ext), 8'(e.ext));
                    check("ev_release", 8'(key_release), 8'(e.rel));
                    check("ev_repeat", 8'(key_repeat), 8'(e.rep));
                    check("ev_key_down", 8'(key_down), 8'(e.down));
                    check("ev_held_code", held_code, e.hcode);
                    check("ev_held_ext", 8'(held_ext), 8'(e.hext));
                    check("ev_press_cnt", press_cnt, e.cnt);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                fail_now("missing_key_valid", 0, 1);
                void'(exp_q.pop_front());
            end
            if (!ps2_nextdata_n && prev_pop) fail_now("pop_two_cycles", 2, 1);
        end
        if (!ps2_nextdata_n) begin
            pop_cnt++;
            if (fifo.size() == 0) begin
                fail_now("pop_empty_fifo", 1, 0);
            end else begin
                b = fifo.pop_front();
                if (!rst) model_byte(b, cyc);
                update_fifo_out();
            end
        end
        prev_pop = !ps2_nextdata_n;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int i;
        repeat (gap) @(negedge clk);
        fifo.push_back(b);
        update_fifo_out();
        for (i = 0; i < 60 && fifo.size() != 0; i++) @(negedge clk);
        if (fifo.size() != 0) fail_now("pop_timeout", fifo.size(), 0);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] codes [5];
        logic [7:0] drops [6];
        logic [7:0] b;
        int         r;
        int         gap;
        int         i;
        codes = '{8'h15, 8'h1C, 8'h23, 8'h75, 8'h6B};
        drops = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
        rst = 1'b1; en = 1'b0; ps2_data = 8'h00; ps2_ready = 1'b0;
        ps2_overflow = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nextdata_n", 8'(ps2_nextdata_n), 8'd1);
        check("rst_key_valid", 8'(key_valid), 8'd0);
        check("rst_key_down", 8'(key_down), 8'd0);
        check("rst_press_cnt", press_cnt, 8'd0);
        check("rst_ovf_err", 8'(ovf_err), 8'd0);
        rst = 1'b0;
        en = 1'b1;

        // Make then break of 15.
        do_reset();
        pop_cnt = 0;
        send(8'h15, 0); settle();
        check("t1_code", key_code, 8'h15);
        check("t1_release", 8'(key_release), 8'd0);
        check("t1_press_cnt", press_cnt, 8'd1);
        check("t1_key_down", 8'(key_down), 8'd1);
        check("t1_held_code", held_code, 8'h15);
        send(8'hF0, 0); send(8'h15, 0); settle();
        check("t1_brk_release", 8'(key_release), 8'd1);
        check("t1_brk_key_down", 8'(key_down), 8'd0);
        check("t1_brk_held_code", held_code, 8'h15);
        check("t1_pops", 8'(pop_cnt), 8'd3);

        // Typematic repeats.
        do_reset();
        send(8'h15, 0); send(8'h15, 1); send(8'h15, 2); settle();
        check("t2_repeat", 8'(key_repeat), 8'd1);
        check("t2_press_cnt", press_cnt, 8'd1);

        // Extended make and break.
        do_reset();
        send(8'hE0, 0); send(8'h75, 0); settle();
        check("t3_code", key_code, 8'h75);
        check("t3_ext", 8'(key_ext), 8'd1);
        check("t3_held_ext", 8'(held_ext), 8'd1);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0); settle();
        check("t3_brk_ext", 8'(key_ext), 8'd1);
        check("t3_brk_release", 8'(key_release), 8'd1);
        check("t3_brk_key_down", 8'(key_down), 8'd0);

        // Stale break prefix discarded after silence.
        do_reset();
        send(8'hF0, 0); send(8'h23, 40); settle();
        check("t4_code", key_code, 8'h23);
        check("t4_release", 8'(key_release), 8'd0);
        check("t4_press_cnt", press_cnt, 8'd1);

        // Status bytes dropped.
        do_reset();
        pop_cnt = 0; valid_cnt = 0;
        send(8'hAA, 0); send(8'hFA, 0); send(8'h00, 0); settle();
        check("t5_valid_cnt", 8'(valid_cnt), 8'd0);
        check("t5_pops", 8'(pop_cnt), 8'd3);
        check("t5_press_cnt", press_cnt, 8'd0);
        send(8'h1C, 0); settle();
        check("t5_code", key_code, 8'h1C);
        check("t5_press_cnt2", press_cnt, 8'd1);

        // Sticky overflow error, set beats clear.
        @(negedge clk); ps2_overflow = 1'b1;
        @(negedge clk); ps2_overflow = 1'b0;
        check("ovf_set", 8'(ovf_err), 8'd1);
        repeat (3) @(negedge clk);
        check("ovf_sticky", 8'(ovf_err), 8'd1);
        ps2_overflow = 1'b1; clr_err = 1'b1;
        @(negedge clk);
        check("ovf_set_wins", 8'(ovf_err), 8'd1);
        ps2_overflow = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 8'(ovf_err), 8'd0);
        clr_err = 1'b0;

        // en=0 leaves the FIFO untouched.
        do_reset();
        en = 1'b0;
        pop_cnt = 0;
        fifo.push_back(8'h1C);
        update_fifo_out();
        repeat (20) @(negedge clk);
        check("en0_pops", 8'(pop_cnt), 8'd0);
        en = 1'b1;
        for (i = 0; i < 60 && fifo.size() != 0; i++) @(negedge clk);
        settle();
        check("en1_code", key_code, 8'h1C);
        check("en1_press_cnt", press_cnt, 8'd1);

        // Reset while the pop strobe is active.
        fifo.push_back(8'h15);
        update_fifo_out();
        for (i = 0; i < 60 && ps2_nextdata_n; i++) @(negedge clk);
        if (ps2_nextdata_n) fail_now("rst_pop_wait", 1, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rstpop_nextdata_n", 8'(ps2_nextdata_n), 8'd1);
        check("rstpop_key_valid", 8'(key_valid), 8'd0);
        check("rstpop_key_code", key_code, 8'h00);
        check("rstpop_key_down", 8'(key_down), 8'd0);
        check("rstpop_held_code", held_code, 8'h00);
        check("rstpop_press_cnt", press_cnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        fifo.delete();
        update_fifo_out();

        // Random byte stream against the model.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r == 5) b = 8'hE0;
            else if (r == 6) b = 8'hF0;
            else if (r == 7) b = drops[$urandom_range(0, 5)];
            else b = codes[$urandom_range(0, 4)];
            gap = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 3);
            send(b, gap);
        end
        settle();
        if (exp_q.size() != 0) fail_now("events_outstanding", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Controller that drains the ps2_keyboard scan-code FIFO through its ready/nextdata_n handshake.
- Parses the PS/2 set-2 byte stream (E0 extended prefix, F0 break prefix) into single-cycle key events.
- Tracks the currently held key, filters typematic repeats and keeps a press counter.
- Sits between ps2_keyboard and the consumers in top (seven-seg display, glyph/VGA selection), replacing ad-hoc decoding there.

Parameters:
- CNT_W, 8, width of press_cnt; wraps modulo 2^CNT_W.
- TIMEOUT_CYC, 2500000, idle clk cycles after which a pending E0/F0 prefix is discarded (100 ms at 25 MHz).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  1 = fetch from FIFO; 0 = hold in IDLE, FIFO untouched.
- ps2_data  in  8  FIFO head byte, valid while ps2_ready=1.
- ps2_ready  in  1  FIFO non-empty.
- ps2_overflow  in  1  FIFO overflow flag.
- ps2_nextdata_n  out  1  active-low pop strobe to the FIFO.
- key_valid  out  1  one-cycle event strobe.
- key_code  out  8  scan code of the event.
- key_ext  out  1  event was E0-prefixed.
- key_release  out  1  event is a break (F0-prefixed).
- key_repeat  out  1  make event is a typematic repeat of the held key.
- key_down  out  1  a key is currently held.
- held_code  out  8  code of the held key.
- held_ext  out  1  extended flag of the held key.
- press_cnt  out  CNT_W  count of non-repeat make events.
- ovf_err  out  1  sticky overflow error.
- clr_err  in  1  clears ovf_err.

Behaviour:
- Reset values: ps2_nextdata_n=1; all other outputs 0; FSM=IDLE; prefix flags and timeout counter cleared.
- FSM states:
  - IDLE: if en & ps2_ready, capture ps2_data into byte_r and go to POP.
  - POP: ps2_nextdata_n=0 for exactly this cycle (decoded from the state register); go to DECODE.
  - DECODE: classify byte_r; go to IDLE.
- Throughput: one byte per 3 cycles. Handshake latency: ready seen in IDLE at cycle N → pop strobe in N+1 → event outputs registered at the end of N+2, so key_valid is high in N+3. The next byte can be accepted in N+3.
- ps2_nextdata_n is never low outside POP and never low for 2 consecutive cycles.
- DECODE classification of byte_r:
  - E0: set ext_pend.
  - F0: set brk_pend.
  - 00, FF, AA, FA, FE, EE: drop the byte, clear both prefixes, no event.
  - Any other byte: pulse key_valid with key_code=byte_r, key_ext=ext_pend, key_release=brk_pend; then clear both prefixes.
- Prefix order: E0 F0 xx and F0 E0 xx both yield ext=1, release=1. Duplicate prefixes are idempotent.
- Make event (release=0):
  - If key_down & held_code==code & held_ext==ext: key_repeat=1 and press_cnt unchanged.
  - Otherwise: key_repeat=0, press_cnt+1 (wraps to 0), and held_code/held_ext/key_down are loaded.
- Break event: key_repeat=0. If it matches the held key, key_down is cleared (held_code retains its value). A break for a non-held key emits the event but leaves held state unchanged.
- key_code, key_ext, key_release and key_repeat hold their values until the next event. key_valid is high for 1 cycle only.
- Timeout: the counter runs while ext_pend|brk_pend is set and is reset by every byte fetch. When it reaches TIMEOUT_CYC-1, both prefixes are cleared and no event is emitted.
- ovf_err is set on any cycle with ps2_overflow=1. clr_err=1 clears it; if set and clear coincide, set wins.
- en deasserted mid-sequence: the current POP/DECODE completes and prefixes are kept. The timeout still applies.
- rst mid-operation returns everything to reset values next cycle; a byte captured but not yet popped stays in the FIFO.

Decomposition:
- Package ps2_pkg:
  - Byte constants: PS2_EXT=E0, PS2_BRK=F0, PS2_BAT=AA, PS2_ACK=FA, PS2_RESEND=FE, PS2_ECHO=EE, PS2_ERR0=00, PS2_ERR1=FF.
  - FSM state enum: IDLE, POP, DECODE.
- Sub-module ps2_timeout_cnt: loadable down-counter with clear and expiry pulse, parameterised by TIMEOUT_CYC.

Test Plan:
- Bytes 15, F0, 15 with a model FIFO:
  - 15 → make event key_code=15, release=0, press_cnt=1, key_down=1, held_code=15.
  - F0 15 → release event, key_down=0.
  - Exactly 3 pop strobes in total.
- Bytes 15, 15, 15 (typematic) → 3 make events, 2nd and 3rd with key_repeat=1, press_cnt=1.
- E0 75 then E0 F0 75 → make event key_code=75 ext=1; then break event ext=1 release=1; held cleared.
- Byte F0 then silence for TIMEOUT_CYC (set to 16 in the bench), then 23 → make event code=23, release=0, press_cnt +1.
- Bytes AA, FA, 00 → no key_valid, 3 pops; then 1C → make event code=1C.
- Protocol and error checks:
  - ps2_overflow pulse → ovf_err=1 and sticky.
  - clr_err held together with ps2_overflow=1 → ovf_err stays 1; clr_err alone → ovf_err=0.
  - en=0 with ready=1 → ps2_nextdata_n stays 1.
  - rst asserted during POP → all outputs at reset values next cycle.
